// File: rtl/mips32_prog_loader_if.sv
// Host byte link, processor memory port and core run controls of the program loader.
// The master modport is the loader's view; slave is the host/memory/core side.
interface mips32_prog_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  // host byte stream in
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  // response byte stream out
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_ready;
  // processor memory port
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  // core run control
  logic              cpu_hold;
  logic              cpu_start;
  logic              cpu_halted;

  modport master (
    input  in_valid, in_data, out_ready, mem_rdata, cpu_halted,
    output in_ready, out_valid, out_data, mem_we, mem_re, mem_addr, mem_wdata,
           cpu_hold, cpu_start
  );

  modport slave (
    output in_valid, in_data, out_ready, mem_rdata, cpu_halted,
    input  in_ready, out_valid, out_data, mem_we, mem_re, mem_addr, mem_wdata,
           cpu_hold, cpu_start
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Byte-serial program loader for the MIPS32 core: WRITE/READ memory words, RUN the core
// until HLT (or watchdog), and report status back to the host.
module mips32_prog_loader #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  mips32_prog_loader_if.master lb
);

  localparam int unsigned CNT_W    = 9;
  localparam int unsigned WDOG_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned WD_LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_RUN   = 8'h03;
  localparam logic [7:0] RSP_HALT  = 8'hA5;
  localparam logic [7:0] RSP_WDOG  = 8'hE1;
  localparam logic [7:0] RSP_BAD   = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_COUNT,
    S_WDATA,
    S_WWRITE,
    S_RREQ,
    S_RCAP,
    S_RSEND,
    S_RUN_START,
    S_RUN_WAIT,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic              rd_q, rd_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              cpu_start_q, cpu_start_d;

  logic accept_c;
  logic send_c;
  logic expire_c;

  assign accept_c = lb.in_valid && in_ready_q;
  assign send_c   = out_valid_q && lb.out_ready;
  assign expire_c = (TIMEOUT != 0) && (wdog_q >= WDOG_W'(WD_LIMIT));

  // State and registered outputs
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hi_q        <= 8'h00;
      addr_q      <= '0;
      cnt_q       <= '0;
      bidx_q      <= 2'd0;
      word_q      <= 32'h0;
      rd_q        <= 1'b0;
      wdog_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      cpu_hold_q  <= 1'b1;
      cpu_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      word_q      <= word_d;
      rd_q        <= rd_d;
      wdog_q      <= wdog_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      cpu_start_q <= cpu_start_d;
    end
  end

  // Next-state and next-output decode; strobes default low, everything else holds
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    word_d      = word_q;
    rd_d        = rd_q;
    wdog_d      = wdog_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    cpu_start_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          unique case (lb.in_data)
            CMD_WRITE: begin
              rd_d    = 1'b0;
              state_d = S_ADDR_HI;
            end
            CMD_READ: begin
              rd_d    = 1'b1;
              state_d = S_ADDR_HI;
            end
            CMD_RUN: begin
              cpu_hold_d  = 1'b0;
              cpu_start_d = 1'b1;
              state_d     = S_RUN_START;
            end
            default: begin
              out_valid_d = 1'b1;
              out_data_d  = RSP_BAD;
              state_d     = S_RESP;
            end
          endcase
        end
      end

      S_ADDR_HI: begin
        if (accept_c) begin
          hi_d    = lb.in_data;
          state_d = S_ADDR_LO;
        end
      end

      S_ADDR_LO: begin
        if (accept_c) begin
          addr_d  = ADDR_W'({hi_q, lb.in_data});
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        if (accept_c) begin
          // count byte 0 encodes a full 256-word burst
          cnt_d  = (lb.in_data == 8'h00) ? CNT_W'(256) : CNT_W'(lb.in_data);
          bidx_d = 2'd0;
          if (rd_q) begin
            mem_re_d   = 1'b1;
            mem_addr_d = addr_q;
            state_d    = S_RREQ;
          end else begin
            state_d = S_WDATA;
          end
        end
      end

      S_WDATA: begin
        if (accept_c) begin
          word_d = {word_q[23:0], lb.in_data};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = {word_q[23:0], lb.in_data};
            state_d     = S_WWRITE;
          end
        end
      end

      S_WWRITE: begin
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? S_IDLE : S_WDATA;
      end

      S_RREQ: begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_RCAP;
      end

      S_RCAP: begin
        // read data is valid this cycle; present the MSB and keep the rest shifted up
        word_d      = {lb.mem_rdata[23:0], 8'h00};
        out_valid_d = 1'b1;
        out_data_d  = lb.mem_rdata[31:24];
        bidx_d      = 2'd0;
        state_d     = S_RSEND;
      end

      S_RSEND: begin
        if (send_c) begin
          if (bidx_q == 2'd3) begin
            out_valid_d = 1'b0;
            cnt_d       = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_IDLE;
            end else begin
              mem_re_d   = 1'b1;
              mem_addr_d = addr_q;
              state_d    = S_RREQ;
            end
          end else begin
            out_data_d = word_q[31:24];
            word_d     = {word_q[23:0], 8'h00};
            bidx_d     = bidx_q + 2'd1;
          end
        end
      end

      S_RUN_START: begin
        wdog_d  = WDOG_W'(1);
        state_d = S_RUN_WAIT;
      end

      S_RUN_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        // a halt in the same cycle as expiry takes priority
        if (lb.cpu_halted) begin
          cpu_hold_d  = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = RSP_HALT;
          state_d     = S_RESP;
        end else if (expire_c) begin
          cpu_hold_d  = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = RSP_WDOG;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        if (send_c) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE)    || (state_d == S_ADDR_HI) ||
                 (state_d == S_ADDR_LO) || (state_d == S_COUNT)   ||
                 (state_d == S_WDATA);
  end

  assign lb.in_ready  = in_ready_q;
  assign lb.out_valid = out_valid_q;
  assign lb.out_data  = out_data_q;
  assign lb.mem_we    = mem_we_q;
  assign lb.mem_re    = mem_re_q;
  assign lb.mem_addr  = mem_addr_q;
  assign lb.mem_wdata = mem_wdata_q;
  assign lb.cpu_hold  = cpu_hold_q;
  assign lb.cpu_start = cpu_start_q;

endmodule
